// File: rtl/clock_pkg.sv
// ============================================================================
// Module : clock_pkg
// Brief  : Shared state encoding, BCD limits and range helper for time setting
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package clock_pkg;

    localparam logic [1:0] ST_RUN     = 2'b00;
    localparam logic [1:0] ST_SET_HR  = 2'b01;
    localparam logic [1:0] ST_SET_MIN = 2'b10;
    localparam logic [1:0] ST_COMMIT  = 2'b11;

    localparam logic [7:0] MIN_TC  = 8'h59;
    localparam logic [7:0] HR24_TC = 8'h23;
    localparam logic [7:0] HR12_TC = 8'h12;

    typedef enum logic [1:0] {
        S_RUN     = ST_RUN,
        S_SET_HR  = ST_SET_HR,
        S_SET_MIN = ST_SET_MIN,
        S_COMMIT  = ST_COMMIT
    } state_t;

    // Valid BCD digits and inside [lo, hi]; BCD orders like plain binary.
    function automatic logic bcd_in_range(input logic [7:0] v,
                                          input logic [7:0] lo,
                                          input logic [7:0] hi);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v >= lo) && (v <= hi);
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_field_inc.sv
// ============================================================================
// Module : bcd_field_inc
// Brief  : Combinational two-digit BCD +1, wrapping MAX_VAL (or illegal) to MIN_VAL
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_field_inc
    import clock_pkg::*;
#(
    parameter logic [7:0] MAX_VAL = 8'h59,
    parameter logic [7:0] MIN_VAL = 8'h00
) (
    input  logic [7:0] val,
    output logic [7:0] nxt
);

    always_comb begin
        nxt = val;
        if (!bcd_in_range(val, MIN_VAL, MAX_VAL) || (val == MAX_VAL)) begin
            nxt = MIN_VAL;
        end else if (val[3:0] == 4'd9) begin
            nxt = {val[7:4] + 4'd1, 4'd0};
        end else begin
            nxt = {val[7:4], val[3:0] + 4'd1};
        end
    end

endmodule

`default_nettype wire

// File: rtl/time_set_ctrl.sv
// ============================================================================
// Module : time_set_ctrl
// Brief  : Two-button HH:MM editor driving the counter-chain load strobe.
//          Optional field blinking is enabled by defining TIME_SET_BLINK_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module time_set_ctrl
    import clock_pkg::*;
#(
    parameter int H24_P = 1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       mode_i,
    input  logic       inc_i,
    input  logic [7:0] hr_count_i,
    input  logic [7:0] min_count_i,
    input  logic       tick_i,
    output logic       nLoadNow_o,
    output logic [7:0] hr_load_o,
    output logic [7:0] min_load_o,
    output logic [7:0] sec_load_o,
    output logic       hold_o,
    output logic [1:0] field_o,
    output logic       blank_o
);

    localparam logic [7:0] c_hr_max = (H24_P != 0) ? HR24_TC : HR12_TC;
    localparam logic [7:0] c_hr_min = (H24_P != 0) ? 8'h00   : 8'h01;
    localparam logic [7:0] c_hr_rst = (H24_P != 0) ? 8'h00   : HR12_TC;

    state_t     r_state, w_state_nxt;
    logic [7:0] r_hr, w_hr_nxt, w_hr_inc;
    logic [7:0] r_min, w_min_nxt, w_min_inc;
    logic       r_mode_prev, r_inc_prev;
    logic       w_mode_ev, w_inc_ev;

    assign w_mode_ev = mode_i & ~r_mode_prev;
    assign w_inc_ev  = inc_i  & ~r_inc_prev;

    bcd_field_inc #(.MAX_VAL(c_hr_max), .MIN_VAL(c_hr_min)) u_hr_inc (
        .val (r_hr),
        .nxt (w_hr_inc)
    );

    bcd_field_inc #(.MAX_VAL(MIN_TC), .MIN_VAL(8'h00)) u_min_inc (
        .val (r_min),
        .nxt (w_min_inc)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_RUN;
            r_hr        <= c_hr_rst;
            r_min       <= 8'h00;
            r_mode_prev <= 1'b0;
            r_inc_prev  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_hr        <= w_hr_nxt;
            r_min       <= w_min_nxt;
            r_mode_prev <= mode_i;
            r_inc_prev  <= inc_i;
        end
    end

    // Mode is tested first in every edit state so a simultaneous inc is dropped.
    always_comb begin
        w_state_nxt = r_state;
        w_hr_nxt    = r_hr;
        w_min_nxt   = r_min;
        case (r_state)
            S_RUN: begin
                if (w_mode_ev) begin
                    w_state_nxt = S_SET_HR;
                    w_hr_nxt    = bcd_in_range(hr_count_i, c_hr_min, c_hr_max)
                                  ? hr_count_i : c_hr_min;
                    w_min_nxt   = bcd_in_range(min_count_i, 8'h00, MIN_TC)
                                  ? min_count_i : 8'h00;
                end
            end
            S_SET_HR: begin
                if (w_mode_ev)     w_state_nxt = S_SET_MIN;
                else if (w_inc_ev) w_hr_nxt    = w_hr_inc;
            end
            S_SET_MIN: begin
                if (w_mode_ev)     w_state_nxt = S_COMMIT;
                else if (w_inc_ev) w_min_nxt   = w_min_inc;
            end
            S_COMMIT: w_state_nxt = S_RUN;
            default:  w_state_nxt = S_RUN;
        endcase
    end

    assign nLoadNow_o = (r_state != S_COMMIT);
    assign hold_o     = (r_state != S_RUN);
    assign field_o    = r_state;
    assign hr_load_o  = r_hr;
    assign min_load_o = r_min;
    assign sec_load_o = 8'h00;

`ifdef TIME_SET_BLINK_EN
    logic r_blank;

    // Cleared on any state change or outside the edit states; inc shows the new value.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_blank <= 1'b0;
        end else if ((w_state_nxt != r_state) ||
                     !((w_state_nxt == S_SET_HR) || (w_state_nxt == S_SET_MIN))) begin
            r_blank <= 1'b0;
        end else if (w_inc_ev) begin
            r_blank <= 1'b0;
        end else if (tick_i) begin
            r_blank <= ~r_blank;
        end
    end

    assign blank_o = r_blank;
`else
    logic w_unused_tick;
    assign w_unused_tick = tick_i;
    assign blank_o       = 1'b0;
`endif

endmodule

`default_nettype wire
